// File: rtl/draw_text_pkg.sv
// Shared defaults, widths and types for the text overlay layer.
package draw_text_pkg;
    localparam int CHAR_W_DEF       = 8;
    localparam int CHAR_H_DEF       = 16;
    localparam int COLS_DEF         = 16;
    localparam int ROWS_DEF         = 16;
    localparam int SCALE_LOG2_DEF   = 0;
    localparam int BLINK_FRAMES_DEF = 30;

    localparam int RGB_W = 12;
    localparam int CNT_W = 11;

    // text_data layout: character code in the low bits, blink attribute on top
    localparam int CODE_LSB  = 0;
    localparam int CODE_MSB  = 6;
    localparam int BLINK_BIT = 7;

    typedef struct packed {
        logic [CNT_W-1:0] vcount;
        logic             vsync;
        logic             vblnk;
        logic [CNT_W-1:0] hcount;
        logic             hsync;
        logic             hblnk;
        logic [RGB_W-1:0] rgb;
    } vga_sb_t;

    typedef struct packed {
        logic             active;
        logic [RGB_W-1:0] fg;
        logic [RGB_W-1:0] bg;
        logic             bg_en;
    } px_ctrl_t;
endpackage

// File: rtl/vga_if.sv
// VGA timing, counters and colour for one pixel stream.
interface vga_if;
    import draw_text_pkg::*;

    logic [CNT_W-1:0] vcount;
    logic             vsync;
    logic             vblnk;
    logic [CNT_W-1:0] hcount;
    logic             hsync;
    logic             hblnk;
    logic [RGB_W-1:0] rgb;

    modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
    modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/delay_upel.sv
// Fixed-depth register delay line, cleared by the asynchronous reset.
module delay_upel #(
    parameter int W     = 1,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [DEPTH-1:0][W-1:0] pipe_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign q_o = pipe_q[DEPTH-1];
endmodule

// File: rtl/draw_text_layer.sv
// Character-grid text overlay: text buffer lookup, font lookup, then colour mux.
// Pixel stream latency is three clocks: text read, font read, output register.
module draw_text_layer
    import draw_text_pkg::*;
#(
    parameter int CHAR_W       = CHAR_W_DEF,
    parameter int CHAR_H       = CHAR_H_DEF,
    parameter int COLS         = COLS_DEF,
    parameter int ROWS         = ROWS_DEF,
    parameter int SCALE_LOG2   = SCALE_LOG2_DEF,
    parameter int BLINK_FRAMES = BLINK_FRAMES_DEF
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              enable,
    input  logic [CNT_W-1:0]                  xpos,
    input  logic [CNT_W-1:0]                  ypos,
    input  logic [RGB_W-1:0]                  fg_rgb,
    input  logic [RGB_W-1:0]                  bg_rgb,
    input  logic                              bg_en,
    output logic [$clog2(COLS*ROWS)-1:0]      text_addr,
    input  logic [7:0]                        text_data,
    output logic [7+$clog2(CHAR_H)-1:0]       font_addr,
    input  logic [CHAR_W-1:0]                 font_line,
    vga_if.in                                 in,
    vga_if.out                                out
);
    localparam int CW_L    = $clog2(CHAR_W);
    localparam int CH_L    = $clog2(CHAR_H);
    localparam int AW      = $clog2(COLS*ROWS);
    localparam int GB      = CNT_W + 1;
    localparam int FW      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [GB-1:0] GRID_W = GB'((COLS*CHAR_W) << SCALE_LOG2);
    localparam logic [GB-1:0] GRID_H = GB'((ROWS*CHAR_H) << SCALE_LOG2);

    // ---- stage T: grid position from the incoming counters
    logic [CNT_W-1:0] dx, dy, col, row;
    logic             in_x, in_y;
    logic [CW_L-1:0]  bit_t;
    logic [CH_L-1:0]  line_t;
    px_ctrl_t         ctrl_t;
    vga_sb_t          sb_t;

    always_comb begin
        dx   = in.hcount - xpos;
        dy   = in.vcount - ypos;
        // order test first so a negative offset never wraps into the grid
        in_x = (in.hcount >= xpos) && ({1'b0, dx} < GRID_W);
        in_y = (in.vcount >= ypos) && ({1'b0, dy} < GRID_H);
        col  = dx >> (CW_L + SCALE_LOG2);
        row  = dy >> (CH_L + SCALE_LOG2);
        text_addr = AW'(row * COLS + col);
        bit_t  = CW_L'(dx >> SCALE_LOG2);
        line_t = CH_L'(dy >> SCALE_LOG2);

        ctrl_t.active = enable & in_x & in_y & ~in.hblnk & ~in.vblnk;
        ctrl_t.fg     = fg_rgb;
        ctrl_t.bg     = bg_rgb;
        ctrl_t.bg_en  = bg_en;

        sb_t.vcount = in.vcount;
        sb_t.vsync  = in.vsync;
        sb_t.vblnk  = in.vblnk;
        sb_t.hcount = in.hcount;
        sb_t.hsync  = in.hsync;
        sb_t.hblnk  = in.hblnk;
        sb_t.rgb    = in.rgb;
    end

    // ---- blink timebase, free-running on vsync rising edges
    logic          vs_q;
    logic [FW-1:0] frame_q, frame_d;
    logic          blink_phase_q, blink_phase_d;

    always_comb begin
        frame_d       = frame_q;
        blink_phase_d = blink_phase_q;
        if (in.vsync && !vs_q) begin
            if (frame_q == FW'(BLINK_FRAMES-1)) begin
                frame_d       = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frame_d = frame_q + 1'b1;
            end
        end
    end

    // ---- stage T+1: font lookup, blink attribute captured with text_data
    logic [CH_L-1:0] line_q;
    logic            hide_q;

    delay_upel #(.W(CH_L), .DEPTH(1)) u_line_dly (
        .clk, .rst_n, .d_i(line_t), .q_o(line_q)
    );

    assign font_addr = {text_data[CODE_MSB:CODE_LSB], line_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q          <= 1'b0;
            frame_q       <= '0;
            blink_phase_q <= 1'b0;
            hide_q        <= 1'b0;
        end else begin
            vs_q          <= in.vsync;
            frame_q       <= frame_d;
            blink_phase_q <= blink_phase_d;
            hide_q        <= text_data[BLINK_BIT] & blink_phase_q;
        end
    end

    // ---- stage T+2: colour select, then the output register
    logic [CW_L-1:0] bit_q;
    px_ctrl_t        ctrl_q;
    vga_sb_t         sb_q, out_d, out_q;
    logic            glyph;

    delay_upel #(.W(CW_L), .DEPTH(2)) u_bit_dly (
        .clk, .rst_n, .d_i(bit_t), .q_o(bit_q)
    );
    delay_upel #(.W($bits(px_ctrl_t)), .DEPTH(2)) u_ctrl_dly (
        .clk, .rst_n, .d_i(ctrl_t), .q_o(ctrl_q)
    );
    delay_upel #(.W($bits(vga_sb_t)), .DEPTH(2)) u_sb_dly (
        .clk, .rst_n, .d_i(sb_t), .q_o(sb_q)
    );

    always_comb begin
        out_d = sb_q;
        // MSB is the leftmost pixel, so bit n of the cell is font_line[W-1-n]
        glyph = font_line[~bit_q] & ~hide_q;
        if (ctrl_q.active) begin
            if (glyph)             out_d.rgb = ctrl_q.fg;
            else if (ctrl_q.bg_en) out_d.rgb = ctrl_q.bg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out_q <= '0;
        else        out_q <= out_d;
    end

    assign out.vcount = out_q.vcount;
    assign out.vsync  = out_q.vsync;
    assign out.vblnk  = out_q.vblnk;
    assign out.hcount = out_q.hcount;
    assign out.hsync  = out_q.hsync;
    assign out.hblnk  = out_q.hblnk;
    assign out.rgb    = out_q.rgb;
endmodule
